// File: rtl/instr_mem_loader_if.sv
// Load/fetch bus of the instruction memory loader.
// The master drives the load stream and fetch requests; the slave is the memory.
interface instr_mem_loader_if #(
  parameter int unsigned INS_ADDRESS = 32,
  parameter int unsigned INS_W       = 32,
  parameter int unsigned DEPTH       = 64
);
  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic                   load_valid;
  logic [INS_W-1:0]       load_data;
  logic                   load_last;
  logic                   load_ready;
  logic                   reload;
  logic                   fetch_req;
  logic [INS_ADDRESS-1:0] fetch_addr;
  logic                   fetch_ready;
  logic                   instr_valid;
  logic [INS_W-1:0]       instruction;
  logic [1:0]             fault;
  logic [LW-1:0]          loaded_words;

  modport master (
    output load_valid, load_data, load_last, reload, fetch_req, fetch_addr,
    input  load_ready, fetch_ready, instr_valid, instruction, fault, loaded_words
  );

  modport slave (
    input  load_valid, load_data, load_last, reload, fetch_req, fetch_addr,
    output load_ready, fetch_ready, instr_valid, instruction, fault, loaded_words
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Instruction memory with a streaming program loader (LOAD) and registered
// 1-cycle-latency fetch port (RUN); faulting fetches return NOP_INSTR.
module instr_mem_loader #(
  parameter int unsigned          INS_ADDRESS = 32,
  parameter int unsigned          INS_W       = 32,
  parameter int unsigned          DEPTH       = 64,
  parameter logic [INS_W-1:0]     NOP_INSTR   = INS_W'(32'h0000_0013)
) (
  input  logic                 clk,
  input  logic                 reset,
  instr_mem_loader_if.slave    bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);

  typedef enum logic {ST_LOAD = 1'b0, ST_RUN = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]    loaded_q, loaded_d;
  logic             instr_valid_q, instr_valid_d;
  logic [INS_W-1:0] instr_q, instr_d;
  logic [1:0]       fault_q, fault_d;
  logic             load_ready_q, fetch_ready_q;
  logic [INS_W-1:0] mem_q [DEPTH];

  logic                   we_c;
  logic [AW-1:0]          waddr_c;
  logic [AW-1:0]          base_ptr_c;
  logic [LW-1:0]          base_cnt_c;
  logic [INS_ADDRESS-1:0] idx_c;
  logic [1:0]             fault_c;

  // Next-state, load pointer and fetch result
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    loaded_d      = loaded_q;
    instr_valid_d = 1'b0;
    instr_d       = instr_q;
    fault_d       = fault_q;
    we_c          = 1'b0;
    waddr_c       = wr_ptr_q;
    base_ptr_c    = bus.reload ? '0 : wr_ptr_q;
    base_cnt_c    = bus.reload ? '0 : loaded_q;
    idx_c         = bus.fetch_addr >> 2;
    fault_c[0]    = (bus.fetch_addr[1:0] != 2'b00);
    fault_c[1]    = (idx_c >= INS_ADDRESS'(loaded_q));

    unique case (state_q)
      ST_LOAD: begin
        wr_ptr_d = base_ptr_c;
        loaded_d = base_cnt_c;
        if (bus.load_valid) begin
          we_c     = 1'b1;
          waddr_c  = base_ptr_c;
          wr_ptr_d = base_ptr_c + AW'(1);
          loaded_d = base_cnt_c + LW'(1);
          // Filling the last word ends the load; the pointer never wraps into live data
          if (bus.load_last || (base_ptr_c == AW'(DEPTH - 1))) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (bus.reload) begin
          state_d  = ST_LOAD;
          wr_ptr_d = '0;
          loaded_d = '0;
        end else if (bus.fetch_req) begin
          instr_valid_d = 1'b1;
          fault_d       = fault_c;
          // idx is only used as an array index once it is known to be below loaded_words
          instr_d       = (fault_c != 2'b00) ? NOP_INSTR : mem_q[idx_c[AW-1:0]];
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_LOAD;
      wr_ptr_q      <= '0;
      loaded_q      <= '0;
      instr_valid_q <= 1'b0;
      instr_q       <= NOP_INSTR;
      fault_q       <= 2'b00;
      load_ready_q  <= 1'b1;
      fetch_ready_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      loaded_q      <= loaded_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      fault_q       <= fault_d;
      load_ready_q  <= (state_d == ST_LOAD);
      fetch_ready_q <= (state_d == ST_RUN);
    end
  end

  // Program storage survives reset and reload
  always_ff @(posedge clk) begin
    if (we_c) begin
      mem_q[waddr_c] <= bus.load_data;
    end
  end

  assign bus.load_ready   = load_ready_q;
  assign bus.fetch_ready  = fetch_ready_q;
  assign bus.instr_valid  = instr_valid_q;
  assign bus.instruction  = instr_q;
  assign bus.fault        = fault_q;
  assign bus.loaded_words = loaded_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader (DEPTH=8): load, fetch, faults,
// full-depth stream, reload and mid-load reset.
module tb_instr_mem_loader;
  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] WA    = 32'hAAAA_0001;
  localparam logic [31:0] WB    = 32'hBBBB_0002;
  localparam logic [31:0] WC    = 32'hCCCC_0003;
  localparam logic [31:0] WX    = 32'h0BAD_F00D;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  instr_mem_loader_if #(.INS_ADDRESS(32), .INS_W(32), .DEPTH(DEPTH)) bus ();

  instr_mem_loader #(
    .INS_ADDRESS(32), .INS_W(32), .DEPTH(DEPTH), .NOP_INSTR(NOP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.load_last  = 1'b0;
    bus.reload     = 1'b0;
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
    #12;
    chk("rst_load_ready", 64'(bus.load_ready), 64'd1);
    chk("rst_fetch_ready", 64'(bus.fetch_ready), 64'd0);
    chk("rst_valid", 64'(bus.instr_valid), 64'd0);
    chk("rst_instr", 64'(bus.instruction), 64'(NOP));
    chk("rst_fault", 64'(bus.fault), 64'd0);
    chk("rst_loaded", 64'(bus.loaded_words), 64'd0);
    step();
    reset = 1'b0;

    // Load A,B,C with fetch_req asserted throughout (must be ignored)
    bus.fetch_req = 1'b1; bus.fetch_addr = 32'd0;
    bus.load_valid = 1'b1; bus.load_data = WA;
    step();
    chk("load_fetch_ignored0", 64'(bus.instr_valid), 64'd0);
    bus.load_data = WB;
    step();
    chk("load_fetch_ignored1", 64'(bus.instr_valid), 64'd0);
    chk("load_cnt2", 64'(bus.loaded_words), 64'd2);
    bus.load_data = WC; bus.load_last = 1'b1;
    step();
    chk("load_fetch_ignored2", 64'(bus.instr_valid), 64'd0);
    chk("run_fetch_ready", 64'(bus.fetch_ready), 64'd1);
    chk("run_load_ready", 64'(bus.load_ready), 64'd0);
    chk("run_loaded3", 64'(bus.loaded_words), 64'd3);
    bus.load_valid = 1'b0; bus.load_last = 1'b0;

    // Back-to-back fetches
    bus.fetch_addr = 32'd0;
    step();
    chk("f0_valid", 64'(bus.instr_valid), 64'd1);
    chk("f0_instr", 64'(bus.instruction), 64'(WA));
    chk("f0_fault", 64'(bus.fault), 64'd0);
    bus.fetch_addr = 32'd4;
    step();
    chk("f4_valid", 64'(bus.instr_valid), 64'd1);
    chk("f4_instr", 64'(bus.instruction), 64'(WB));
    bus.fetch_addr = 32'd8;
    step();
    chk("f8_instr", 64'(bus.instruction), 64'(WC));
    chk("f8_fault", 64'(bus.fault), 64'd0);
    bus.fetch_addr = 32'd12;
    step();
    chk("f12_instr", 64'(bus.instruction), 64'(NOP));
    chk("f12_fault", 64'(bus.fault), 64'd2);
    bus.fetch_addr = 32'h4000_0004;
    step();
    chk("fhuge_instr", 64'(bus.instruction), 64'(NOP));
    chk("fhuge_fault", 64'(bus.fault), 64'd2);
    bus.fetch_addr = 32'd6;
    step();
    chk("f6_instr", 64'(bus.instruction), 64'(NOP));
    chk("f6_fault", 64'(bus.fault), 64'd1);
    bus.fetch_addr = 32'd14;
    step();
    chk("f14_fault", 64'(bus.fault), 64'd3);
    bus.fetch_addr = 32'd6;
    step();
    bus.fetch_req = 1'b0; bus.fetch_addr = 32'd4;
    step();
    chk("idle_valid", 64'(bus.instr_valid), 64'd0);
    chk("idle_instr_hold", 64'(bus.instruction), 64'(NOP));
    chk("idle_fault_hold", 64'(bus.fault), 64'd1);

    // Reload with simultaneous fetch: fetch dropped
    bus.reload = 1'b1; bus.fetch_req = 1'b1; bus.fetch_addr = 32'd0;
    step();
    chk("rl_valid", 64'(bus.instr_valid), 64'd0);
    chk("rl_load_ready", 64'(bus.load_ready), 64'd1);
    chk("rl_loaded", 64'(bus.loaded_words), 64'd0);
    bus.reload = 1'b0; bus.fetch_req = 1'b0;

    // Stream DEPTH words without load_last
    bus.load_valid = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) begin
      bus.load_data = 32'h1000_0000 + 32'(i);
      step();
      if (i == int'(DEPTH) - 2) begin
        chk("full_still_load", 64'(bus.load_ready), 64'd1);
        chk("full_cnt7", 64'(bus.loaded_words), 64'd7);
      end
    end
    chk("full_run", 64'(bus.fetch_ready), 64'd1);
    chk("full_cnt", 64'(bus.loaded_words), 64'(DEPTH));
    bus.load_data = 32'hDEAD_BEEF;
    step();
    chk("full_ignore_load", 64'(bus.loaded_words), 64'(DEPTH));
    bus.load_valid = 1'b0;
    bus.fetch_req = 1'b1; bus.fetch_addr = 32'((DEPTH - 1) * 4);
    step();
    chk("full_last_word", 64'(bus.instruction), 64'h1000_0007);
    chk("full_last_fault", 64'(bus.fault), 64'd0);
    bus.fetch_addr = 32'd0;
    step();
    chk("full_first_word", 64'(bus.instruction), 64'h1000_0000);
    bus.fetch_addr = 32'(DEPTH * 4);
    step();
    chk("full_oob_fault", 64'(bus.fault), 64'd2);
    bus.fetch_req = 1'b0;

    // Reload in LOAD with simultaneous word restarts at index 0
    bus.reload = 1'b1;
    step();
    bus.reload = 1'b0; bus.load_valid = 1'b1; bus.load_data = 32'h2222_0000;
    step();
    bus.load_data = 32'h2222_0001;
    step();
    chk("ld2_cnt", 64'(bus.loaded_words), 64'd2);
    bus.reload = 1'b1; bus.load_data = 32'h3333_0000;
    step();
    chk("ld_reload_cnt", 64'(bus.loaded_words), 64'd1);
    bus.reload = 1'b0; bus.load_data = 32'h3333_0001;
    step();
    chk("ld_reload_cnt2", 64'(bus.loaded_words), 64'd2);
    bus.load_valid = 1'b0;

    // Async reset mid-load
    reset = 1'b1;
    #2;
    chk("mid_rst_ready", 64'(bus.load_ready), 64'd1);
    chk("mid_rst_cnt", 64'(bus.loaded_words), 64'd0);
    chk("mid_rst_instr", 64'(bus.instruction), 64'(NOP));
    #2;
    reset = 1'b0;
    bus.load_valid = 1'b1; bus.load_last = 1'b1; bus.load_data = WX;
    step();
    chk("x_run", 64'(bus.fetch_ready), 64'd1);
    chk("x_cnt", 64'(bus.loaded_words), 64'd1);
    bus.load_valid = 1'b0; bus.load_last = 1'b0;
    bus.fetch_req = 1'b1; bus.fetch_addr = 32'd0;
    step();
    chk("x_valid", 64'(bus.instr_valid), 64'd1);
    chk("x_instr", 64'(bus.instruction), 64'(WX));
    bus.fetch_addr = 32'd4;
    step();
    chk("x_oob_fault", 64'(bus.fault), 64'd2);
    bus.fetch_req = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
